// File: rtl/seal_crc16_engine.sv
// seal_crc16_engine: CRC-16/CCITT-FALSE engine shared by the seal register and a CPU peripheral slot.
// Define CRC_PARALLEL_EN for a one-cycle byte engine; the default build is bit-serial (8 cycles per byte).
module seal_crc16_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seal_byte,
    input  logic        seal_feed,
    input  logic        seal_init,
    input  logic [7:0]  cpu_byte,
    input  logic        cpu_feed,
    input  logic        cpu_init,
    input  logic        status_rd,
    output logic        crc_busy,
    output logic [15:0] crc_value,
    output logic [31:0] status
);
    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] crc_q, crc_d, crc_base;
    logic [3:0]  seal_cnt_q, seal_cnt_d, seal_cnt_base;
    logic        seal_owner_q, seal_owner_d;
    logic        cpu_dropped_q, cpu_dropped_d;
    logic        shift, cpu_block, seal_feed_ok, cpu_feed_ok, cpu_init_ok, feed_ok;
    logic        seal_done, abort_cpu;
    logic [7:0]  byte_in;

`ifndef CRC_PARALLEL_EN
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       src_cpu_q, src_cpu_d;

    assign shift = state_q == SHIFT;

    // The first bit is folded in on the accept edge, so SHIFT lasts 7 cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        src_cpu_d = src_cpu_q;
        crc_d     = crc_base;
        abort_cpu = seal_init & shift & src_cpu_q;
        seal_done = shift & ~seal_init & (cnt_q == 3'd7) & ~src_cpu_q;
        if (feed_ok) begin
            state_d   = SHIFT;
            cnt_d     = 3'd1;
            sr_d      = {byte_in[6:0], 1'b0};
            src_cpu_d = ~seal_feed_ok;
            crc_d     = crc_bit(crc_base, byte_in[7]);
        end else if (seal_init | cpu_init_ok) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else if (shift) begin
            crc_d   = crc_bit(crc_q, sr_q[7]);
            sr_d    = {sr_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'd7) ? IDLE : SHIFT;
        end
    end
`else
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = crc_bit(r, d[i]);
        return r;
    endfunction

    assign shift = 1'b0;

    always_comb begin
        crc_d     = feed_ok ? crc_byte(crc_base, byte_in) : crc_base;
        abort_cpu = 1'b0;
        seal_done = seal_feed_ok;
    end
`endif

    always_comb begin
        cpu_block     = shift | seal_init | seal_feed | seal_owner_q;
        seal_feed_ok  = seal_feed & (~shift | seal_init);
        cpu_feed_ok   = cpu_feed & ~cpu_block;
        cpu_init_ok   = cpu_init & ~cpu_block;
        feed_ok       = seal_feed_ok | cpu_feed_ok;
        byte_in       = seal_feed_ok ? seal_byte : cpu_byte;
        crc_base      = (seal_init | cpu_init_ok) ? 16'hFFFF : crc_q;
        crc_busy      = shift | seal_feed | cpu_feed_ok;
        seal_cnt_base = seal_init ? 4'd0 : seal_cnt_q;
        seal_cnt_d    = (seal_done && seal_cnt_base != 4'hF) ? seal_cnt_base + 4'd1 : seal_cnt_base;
        // Ownership ends when the ninth seal byte since seal_init completes.
        seal_owner_d  = ((seal_done && seal_cnt_base == 4'd8) || cpu_init_ok) ? 1'b0 :
                        seal_feed_ok ? 1'b1 : seal_owner_q;
        cpu_dropped_d = ((cpu_feed | cpu_init) & cpu_block) | abort_cpu | (cpu_dropped_q & ~status_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q         <= 16'hFFFF;
            seal_cnt_q    <= 4'd0;
            seal_owner_q  <= 1'b0;
            cpu_dropped_q <= 1'b0;
`ifndef CRC_PARALLEL_EN
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            sr_q          <= 8'd0;
            src_cpu_q     <= 1'b0;
`endif
        end else begin
            crc_q         <= crc_d;
            seal_cnt_q    <= seal_cnt_d;
            seal_owner_q  <= seal_owner_d;
            cpu_dropped_q <= cpu_dropped_d;
`ifndef CRC_PARALLEL_EN
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            src_cpu_q     <= src_cpu_d;
`endif
        end
    end

    assign crc_value = crc_q;
    assign status    = {29'd0, cpu_dropped_q, seal_owner_q, crc_busy};
endmodule

// File: tb/tb_seal_crc16_engine.sv
// tb_seal_crc16_engine: directed vectors for seal_crc16_engine with hand-computed CRC values.
// Expectations follow CRC_PARALLEL_EN when the bench is built with that macro.
module tb_seal_crc16_engine;
    logic        clk, rst;
    logic [7:0]  seal_byte, cpu_byte;
    logic        seal_feed, seal_init, cpu_feed, cpu_init, status_rd;
    logic        crc_busy;
    logic [15:0] crc_value;
    logic [31:0] status;
    int          checks, errors, n;

`ifdef CRC_PARALLEL_EN
    localparam int          BUSY_CYC  = 1;
    localparam logic [15:0] FIRST_BIT = 16'hE1F0;
    localparam logic [31:0] ABORT_ST  = 32'd0;
`else
    localparam int          BUSY_CYC  = 8;
    localparam logic [15:0] FIRST_BIT = 16'hEFDF;
    localparam logic [31:0] ABORT_ST  = 32'd4;
`endif

    seal_crc16_engine dut (
        .clk(clk), .rst(rst),
        .seal_byte(seal_byte), .seal_feed(seal_feed), .seal_init(seal_init),
        .cpu_byte(cpu_byte), .cpu_feed(cpu_feed), .cpu_init(cpu_init),
        .status_rd(status_rd), .crc_busy(crc_busy), .crc_value(crc_value), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_pulses();
        seal_feed = 1'b0;
        seal_init = 1'b0;
        cpu_feed  = 1'b0;
        cpu_init  = 1'b0;
        status_rd = 1'b0;
    endtask

    task automatic pulse(input logic si, input logic ci, input logic cf, input logic rd);
        @(negedge clk);
        seal_init = si;
        cpu_init  = ci;
        cpu_feed  = cf;
        status_rd = rd;
        @(negedge clk);
        clear_pulses();
        #1;
    endtask

    task automatic feed_wait(input logic si, input logic sf, input logic [7:0] sb,
                             input logic cf, input logic [7:0] cb, output int cnt);
        logic b;
        @(negedge clk);
        seal_init = si;
        seal_feed = sf;
        seal_byte = sb;
        cpu_feed  = cf;
        cpu_byte  = cb;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            b = crc_busy;
            if (b) cnt++;
            @(negedge clk);
            clear_pulses();
            if (!b) break;
        end
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!crc_busy) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] msg [9];
        checks = 0;
        errors = 0;
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        seal_byte = 8'h00;
        cpu_byte  = 8'h00;
        clear_pulses();
        rst = 1'b1;
        #3;
        check("reset_crc", 32'(crc_value), 32'hFFFF);
        check("reset_status", status, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("cpu_init_crc", 32'(crc_value), 32'hFFFF);
        feed_wait(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, n);
        check("cpu_00_busy_cycles", 32'(n), 32'(BUSY_CYC));
        check("cpu_00_crc", 32'(crc_value), 32'hE1F0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cpu_feed = 1'b1;
        cpu_byte = 8'h00;
        @(negedge clk);
        cpu_feed = 1'b0;
        #1;
        check("cpu_00_first_edge", 32'(crc_value), 32'(FIRST_BIT));
        wait_idle();
        check("cpu_00_crc_again", 32'(crc_value), 32'hE1F0);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            feed_wait(1'b0, 1'b1, msg[i], 1'b0, 8'h00, n);
            check($sformatf("seal_busy_byte%0d", i), 32'(n), 32'(BUSY_CYC));
            if (i == 0) check("seal_owner_set", status, 32'd2);
        end
        check("seal_123456789_crc", 32'(crc_value), 32'h29B1);
        check("seal_owner_clear_9th", status, 32'd0);

        feed_wait(1'b1, 1'b1, 8'h00, 1'b1, 8'h41, n);
        check("contend_crc", 32'(crc_value), 32'hE1F0);
        check("contend_status", status, 32'd6);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("drop_and_read_same_cycle", status, 32'd6);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("status_rd_clears", status, 32'd2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("cpu_init_blocked_crc", 32'(crc_value), 32'hE1F0);
        check("cpu_init_blocked_status", status, 32'd6);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cpu_feed = 1'b1;
        cpu_byte = 8'h41;
        @(negedge clk);
        cpu_feed = 1'b0;
`ifndef CRC_PARALLEL_EN
        seal_feed = 1'b1;
        seal_byte = 8'hFF;
`endif
        @(negedge clk);
        seal_feed = 1'b0;
        wait_idle();
        check("cpu_41_crc", 32'(crc_value), 32'hB915);
        check("cpu_41_status", status, 32'd0);

        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cpu_feed = 1'b1;
        @(negedge clk);
        cpu_feed = 1'b0;
        @(negedge clk);
        @(negedge clk);
        seal_init = 1'b1;
        @(negedge clk);
        seal_init = 1'b0;
        #1;
        check("abort_crc", 32'(crc_value), 32'hFFFF);
        check("abort_busy", 32'(crc_busy), 32'd0);
        check("abort_status", status, ABORT_ST);

        @(negedge clk);
        cpu_feed = 1'b1;
        cpu_byte = 8'h41;
        @(negedge clk);
        cpu_feed = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_shift_crc", 32'(crc_value), 32'hFFFF);
        check("rst_mid_shift_busy", 32'(crc_busy), 32'd0);
        check("rst_mid_shift_status", status, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("after_rst_status", status, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seal_crc16_engine.md
SEAL_CRC16_ENGINE -- requirements
Module: seal_crc16_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port seal_byte, input, 8 bits: data byte from the seal register.
REQ-004 SHALL have port seal_feed, input, 1 bit: single-cycle pulse requesting processing of seal_byte.
REQ-005 SHALL have port seal_init, input, 1 bit: single-cycle pulse that loads 0xFFFF into the CRC.
REQ-006 SHALL have port cpu_byte, input, 8 bits: data byte from the CPU CRC peripheral slot.
REQ-007 SHALL have port cpu_feed, input, 1 bit: single-cycle pulse (write-complete) requesting processing of cpu_byte.
REQ-008 SHALL have port cpu_init, input, 1 bit: single-cycle pulse loading 0xFFFF.
REQ-009 SHALL have port crc_busy, output, 1 bit: engine is shifting or is accepting a byte this cycle.
REQ-010 SHALL have port crc_value, output, 16 bits: current CRC register.
REQ-011 SHALL have port status, output, 32 bits: {29'b0, cpu_dropped, seal_owner, crc_busy}.
REQ-012 SHALL have port status_rd, input, 1 bit: single-cycle pulse on CPU status read; clears cpu_dropped.

Function
REQ-013 SHALL compute CRC-16/CCITT-FALSE: poly 0x1021, MSB-first, no reflection, no final XOR.
REQ-014 SHALL use states IDLE and SHIFT; bit counter 3 bits, shift register 8 bits.
REQ-015 In IDLE, an accepted feed SHALL latch the byte, enter SHIFT and process one bit per cycle for 8 cycles, then return to IDLE; 8 cycles from accept to final crc_value.
REQ-016 crc_busy SHALL be combinational: (state==SHIFT) OR seal_feed OR (cpu_feed AND accepted); it is therefore high in the same cycle as an accepted feed pulse.
REQ-017 Priority SHALL be seal_init > seal_feed > cpu_init > cpu_feed.
REQ-018 seal_init SHALL load 0xFFFF in any state, abort any SHIFT in progress and return to IDLE; an aborted CPU byte SHALL set cpu_dropped.
REQ-019 Same-cycle init and feed on one port SHALL load 0xFFFF, then shift the byte from 0xFFFF.
REQ-020 seal_feed in IDLE SHALL always be accepted and set seal_owner; seal_owner SHALL clear when the 9th seal byte after seal_init completes or when cpu_init is accepted.
REQ-021 cpu_feed or cpu_init SHALL be dropped and set cpu_dropped when state==SHIFT, when seal_init or seal_feed is present in the same cycle, or when seal_owner=1.
REQ-022 cpu_dropped SHALL be sticky; status_rd clears it; set and clear in the same cycle SHALL leave it set.
REQ-023 seal_feed while state==SHIFT SHALL be ignored.
REQ-024 crc_value SHALL update only on shift cycles, init loads and reset.

Reset
REQ-025 rst SHALL force state=IDLE, crc_value=0xFFFF, bit counter=0, seal_owner=0, cpu_dropped=0 and crc_busy=0 (with feeds low), asynchronously.
REQ-026 Assertion of rst mid-SHIFT SHALL discard the partial byte, with no flag set.

Configuration
REQ-027 Macro CRC_PARALLEL_EN defined: the engine SHALL process the whole byte in one cycle; no SHIFT state; crc_busy = accepted feed only; result visible the cycle after accept.
REQ-028 Macro CRC_PARALLEL_EN undefined: the engine SHALL use the bit-serial 8-cycle engine of REQ-014/015.
REQ-029 In both configurations, CRC results, priority and flags SHALL be identical.

Verification
REQ-030 seal_init, then bytes "123456789" (0x31..0x39) fed on seal_feed, each fed when crc_busy=0 -> crc_value=0x29B1.
REQ-031 cpu_init, then cpu_feed 0x00 -> crc_value=0xE1F0 after 8 cycles, crc_busy high for exactly 8 cycles including the accept cycle.
REQ-032 cpu_feed 0x41 with seal_feed 0x00 in the same cycle -> seal byte processed, cpu_dropped=1, status[2]=1; status_rd -> status[2]=0.
REQ-033 cpu_feed 0x41, then seal_init on cycle 4 of SHIFT -> crc_value=0xFFFF next cycle, state IDLE, cpu_dropped=1.
REQ-034 rst asserted on shift cycle 5 -> crc_value=0xFFFF immediately, crc_busy=0, status=0.
REQ-035 Repeat REQ-030 with CRC_PARALLEL_EN defined -> 0x29B1, crc_busy high exactly 1 cycle per byte.
